// File: rtl/mult_sched_pkg.sv
// Shared constants for the multiplier scheduler slice.
package mult_sched_pkg;

    // Cycles from the core input-register load to a valid registered product.
    localparam int unsigned MULT_LAT = 2;

    // Response entry layout is {product, requester id}.
    function automatic int unsigned rsp_width(input int unsigned n, input int unsigned idw);
        return 2 * n + idw;
    endfunction

endpackage

// File: rtl/mult_rsp_fifo.sv
// Show-ahead response FIFO with occupancy count; head is valid whenever count is non-zero.
module mult_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop     = pop && (count_q != '0);
        head_valid = (count_q != '0);
        head_data  = mem_q[rd_ptr_q];
        count      = count_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The upstream credit scheme must make an overflowing push unreachable.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == CW'(DEPTH)))
        else $error("mult_rsp_fifo: push while full");

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one registered multiplier core; results return in
// issue order through a credit-limited response FIFO.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*N-1:0]       rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 mult_ea,
    output logic                 mult_eb,
    output logic [N-1:0]         mult_data_a,
    output logic [N-1:0]         mult_data_b,
    input  logic [2*N-1:0]       mult_p,
    output logic                 busy
);

    localparam int unsigned OCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RW  = rsp_width(N, IDW);

    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [MULT_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [IDW-1:0]      tag_id_q [MULT_LAT];
    logic [IDW-1:0]      tag_id_d [MULT_LAT];
    logic [NUM_REQ-1:0]  vld_rot;
    logic                grant_found;
    logic [IDW-1:0]      grant_id;
    logic                issue;
    logic [OCW-1:0]      occ;
    logic [OCW-1:0]      fifo_count;
    logic [RW-1:0]       fifo_head;

    // Rotating the valids by rr_ptr turns the wrapped search into a plain priority scan.
    always_comb begin
        vld_rot     = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && vld_rot[i]) begin
                grant_found = 1'b1;
                grant_id    = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
        occ = fifo_count;
        for (int unsigned s = 0; s < MULT_LAT; s++) begin
            occ = occ + OCW'(tag_vld_q[s]);
        end
        // No handshake while held in reset: the core registers cannot capture it.
        issue = rst_n && grant_found && (occ < OCW'(FIFO_DEPTH));
    end

    always_comb begin
        req_ready   = '0;
        mult_data_a = '0;
        mult_data_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (issue && grant_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                mult_data_a  = req_a[i*N +: N];
                mult_data_b  = req_b[i*N +: N];
            end
        end
        mult_ea = issue;
        mult_eb = issue;
        busy    = (occ != '0);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        tag_vld_d[0] = issue;
        tag_id_d[0]  = grant_id;
        for (int unsigned s = 1; s < MULT_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int unsigned s = 0; s < MULT_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    mult_rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (tag_vld_q[MULT_LAT-1]),
        .push_data  ({mult_p, tag_id_q[MULT_LAT-1]}),
        .pop        (rsp_ready),
        .head_valid (rsp_valid),
        .head_data  (fifo_head),
        .count      (fifo_count)
    );

    assign rsp_data = fifo_head[RW-1:IDW];
    assign rsp_id   = fifo_head[IDW-1:0];

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: transaction-level scoreboard plus directed scenarios.
module tb_mult_sched;

    localparam int N  = 8;
    localparam int NR = 4;
    localparam int FD = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NR-1:0]    req_valid, req_ready;
    logic [NR*N-1:0]  req_a, req_b;
    logic             rsp_valid, rsp_ready;
    logic [2*N-1:0]   rsp_data;
    logic [1:0]       rsp_id;
    logic             mult_ea, mult_eb;
    logic [N-1:0]     mult_data_a, mult_data_b;
    logic [2*N-1:0]   mult_p;
    logic             busy;

    logic [3:0]  r4_valid, r4_ready;
    logic [15:0] r4_a, r4_b;
    logic        r4_rsp_valid;
    logic [7:0]  r4_rsp_data;
    logic [1:0]  r4_rsp_id;
    logic        r4_ea, r4_eb;
    logic [3:0]  r4_da, r4_db;
    logic [7:0]  r4_p;
    logic        r4_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mult_sched #(.N(N), .NUM_REQ(NR), .FIFO_DEPTH(FD)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .mult_ea(mult_ea), .mult_eb(mult_eb),
        .mult_data_a(mult_data_a), .mult_data_b(mult_data_b), .mult_p(mult_p), .busy(busy)
    );

    mult_sched #(.N(4), .NUM_REQ(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(r4_valid), .req_a(r4_a), .req_b(r4_b),
        .req_ready(r4_ready), .rsp_valid(r4_rsp_valid), .rsp_ready(1'b1),
        .rsp_data(r4_rsp_data), .rsp_id(r4_rsp_id), .mult_ea(r4_ea), .mult_eb(r4_eb),
        .mult_data_a(r4_da), .mult_data_b(r4_db), .mult_p(r4_p), .busy(r4_busy)
    );

    // External multiplier cores: input registers, combinational multiply, output register.
    logic [N-1:0] ca, cb;
    logic [3:0]   ca4, cb4;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca <= '0; cb <= '0; mult_p <= '0;
            ca4 <= '0; cb4 <= '0; r4_p <= '0;
        end else begin
            if (mult_ea) ca <= mult_data_a;
            if (mult_eb) cb <= mult_data_b;
            mult_p <= 16'(ca) * 16'(cb);
            if (r4_ea) ca4 <= r4_da;
            if (r4_eb) cb4 <= r4_db;
            r4_p <= 8'(ca4) * 8'(cb4);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*N +: N] = N'(a);
        req_b[i*N +: N] = N'(b);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard: every issued-but-not-popped transaction, in issue order.
    typedef struct {int p; int id; int t;} exp_t;
    typedef struct {int p; int id;} rsp_t;
    exp_t mq[$];
    rsp_t log_q[$];
    int   m_rr = 0;
    int   gid, idx, prod;
    logic [NR-1:0] e_rdy;
    logic [N-1:0]  ea, eb;
    logic          hv;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            m_rr = 0;
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_mult_ea", 32'(mult_ea), 0);
            check("rst_mult_eb", 32'(mult_eb), 0);
            check("rst_data_a", 32'(mult_data_a), 0);
            check("rst_data_b", 32'(mult_data_b), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_data", 32'(rsp_data), 0);
            check("rst_rsp_id", 32'(rsp_id), 0);
            check("rst_busy", 32'(busy), 0);
        end else begin
            gid = -1;
            if (mq.size() < FD) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_rr + k) % NR;
                    if (gid < 0 && req_valid[idx]) gid = idx;
                end
            end
            e_rdy = '0; ea = '0; eb = '0;
            if (gid >= 0) begin
                e_rdy = NR'(1) << gid;
                ea = N'(req_a >> (gid * N));
                eb = N'(req_b >> (gid * N));
            end
            hv = (mq.size() > 0) && (cyc >= mq[0].t + 3);
            check("req_ready", 32'(req_ready), 32'(e_rdy));
            check("mult_ea", 32'(mult_ea), 32'(gid >= 0));
            check("mult_eb", 32'(mult_eb), 32'(gid >= 0));
            check("mult_data_a", 32'(mult_data_a), 32'(ea));
            check("mult_data_b", 32'(mult_data_b), 32'(eb));
            check("busy", 32'(busy), 32'(mq.size() > 0));
            check("rsp_valid", 32'(rsp_valid), 32'(hv));
            if (hv) begin
                check("rsp_data", 32'(rsp_data), 32'(mq[0].p));
                check("rsp_id", 32'(rsp_id), 32'(mq[0].id));
                if (rsp_ready) void'(mq.pop_front());
            end
            if (rsp_valid && rsp_ready) log_q.push_back('{p: int'(rsp_data), id: int'(rsp_id)});
            if (gid >= 0) begin
                prod = int'(ea) * int'(eb);
                mq.push_back('{p: prod, id: gid, t: cyc});
                m_rr = (gid + 1) % NR;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n, nis, nv;

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        r4_valid = '0; r4_a = '0; r4_b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 2
        set_op(2, 7, 9); req_valid = 4'b0100;
        #3 check("t1_grant", 32'(req_ready), 32'h4);
        step(); req_valid = '0;
        #3; n = 1;
        while (!rsp_valid && n < 20) begin step(); #3; n++; end
        check("t1_latency", n, 3);
        check("t1_data", 32'(rsp_data), 63);
        check("t1_id", 32'(rsp_id), 2);
        step(); #3;
        check("t1_busy", 32'(busy), 0);

        // All four requesters streaming
        do_reset(); log_q.delete();
        for (int i = 0; i < NR; i++) set_op(i, i + 1, 10);
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            #3 check("t2_grant", 32'(req_ready), 32'(1) << (c % 4));
            step();
        end
        req_valid = '0;
        repeat (10) step();
        check("t2_count", log_q.size(), 8);
        for (int k = 0; k < 4; k++) begin
            check("t2_data", log_q[k].p, 10 * (k + 1));
            check("t2_id", log_q[k].id, k);
        end

        // Backpressure: credits run out at FIFO_DEPTH
        do_reset(); log_q.delete(); rsp_ready = 1'b0;
        set_op(0, 255, 255); req_valid = 4'b0001; nis = 0;
        for (int c = 0; c < 10; c++) begin
            #3 if (req_ready[0]) nis++;
            step();
        end
        check("t3_issues", nis, 4);
        #3 check("t3_stall", 32'(req_ready), 0);
        check("t3_head", 32'(rsp_data), 65025);
        check("t3_nopop", log_q.size(), 0);
        step(); rsp_ready = 1'b1;
        repeat (3) step();
        req_valid = '0;
        repeat (12) step();
        check("t3_popped", log_q.size(), 6);
        foreach (log_q[k]) check("t3_val", log_q[k].p, 65025);

        // Fairness after the pointer wraps
        do_reset();
        set_op(3, 2, 3); req_valid = 4'b1000;
        #3 check("t4_first", 32'(req_ready), 32'h8);
        step(); set_op(1, 4, 5); req_valid = 4'b1010;
        #3 check("t4_fair", 32'(req_ready), 32'h2);
        step(); req_valid = 4'b1000;
        #3 check("t4_next", 32'(req_ready), 32'h8);
        step(); req_valid = '0;
        repeat (8) step();

        // Reset while transactions are in flight
        do_reset(); log_q.delete();
        set_op(0, 3, 4); req_valid = 4'b0001;
        step(); set_op(1, 5, 6); req_valid = 4'b0010; rst_n = 1'b0;
        #3 check("t5_rst_ready", 32'(req_ready), 0);
        step(); step(); rst_n = 1'b1; req_valid = '0; nv = 0;
        for (int c = 0; c < 10; c++) begin
            #3 if (rsp_valid) nv++;
            step();
        end
        check("t5_no_rsp", nv, 0);
        check("t5_no_log", log_q.size(), 0);
        set_op(0, 6, 7); req_valid = 4'b0001;
        #3 check("t5_grant", 32'(req_ready), 32'h1);
        step(); req_valid = '0;
        #3; n = 1;
        while (!rsp_valid && n < 20) begin step(); #3; n++; end
        check("t5_latency", n, 3);
        check("t5_data", 32'(rsp_data), 42);
        repeat (4) step();

        // Edge operands
        do_reset(); log_q.delete();
        set_op(0, 0, 255); set_op(1, 255, 1); req_valid = 4'b0011;
        step(); req_valid = 4'b0010;
        step(); req_valid = '0;
        repeat (8) step();
        check("t6_count", log_q.size(), 2);
        check("t6_zero", log_q[0].p, 0);
        check("t6_ident", log_q[1].p, 255);
        check("t6_id", log_q[1].id, 1);

        // N=4 override: full-scale operands
        r4_a[3:0] = 4'd15; r4_b[3:0] = 4'd15; r4_valid = 4'b0001;
        #3 check("n4_grant", 32'(r4_ready), 32'h1);
        step(); r4_valid = '0;
        #3; n = 1;
        while (!r4_rsp_valid && n < 20) begin step(); #3; n++; end
        check("n4_latency", n, 3);
        check("n4_data", 32'(r4_rsp_data), 225);
        check("n4_id", 32'(r4_rsp_id), 0);
        step(); #3;
        check("n4_busy", 32'(r4_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
